apu_frame_ctrl: RTL and testbench
=================================

Name: apu_frame_ctrl

Overview:
- Controller for the APU frame counter.
- Captures CPU writes to the frame-counter register ($4017) and holds the new mode bits in a shadow register.
- Applies the write to the frame counter after the hardware-accurate 3- or 4-CPU-cycle delay, producing the counter's mode_in/mode_wr_in.
- Owns the frame IRQ flag (set, clear, status read) and merges the immediate quarter/half-frame clock into the envelope/length pulse outputs.

Parameters:
DLY_EVEN, 3, CPU cycles from write to apply when the write cycle coincides with an APU cycle pulse
DLY_ODD, 4, CPU cycles from write to apply otherwise
CNT_W, 3, delay counter width; must hold max(DLY_EVEN, DLY_ODD)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
cpu_cycle_pulse_in  input  1  1-clk pulse per CPU cycle
apu_cycle_pulse_in  input  1  1-clk pulse per APU cycle (every 2nd CPU cycle)
wr_in  input  1  $4017 write strobe; qualified by cpu_cycle_pulse_in
d_in  input  8  write data; [7]=sequence mode, [6]=IRQ inhibit
status_rd_in  input  1  $4015 read strobe; qualified by cpu_cycle_pulse_in
fc_e_pulse_in  input  1  envelope pulse from frame counter
fc_l_pulse_in  input  1  length/sweep pulse from frame counter
fc_f_pulse_in  input  1  frame pulse from frame counter (already inhibit-gated)
mode_out  output  2  to frame counter mode_in: [1]=seq mode, [0]=IRQ inhibit
mode_wr_out  output  1  to frame counter mode_wr_in
e_pulse_out  output  1  merged envelope/linear-counter pulse
l_pulse_out  output  1  merged length/sweep pulse
irq_out  output  1  frame IRQ flag; also drives $4015 bit 6
busy_out  output  1  write pending (state DELAY)

Behaviour:
- Reset: all state clears asynchronously. mode_out=2'b00, irq flag=0, state=IDLE, counter=0. All outputs are 0. A reset during DELAY discards the pending write; no mode_wr_out is issued afterwards.
- A write is accepted when wr_in & cpu_cycle_pulse_in in the same clk.
  - On accept, the shadow register is loaded: mode_out <= {d_in[7], d_in[6]}. mode_out stays stable until the next accepted write.
  - On accept, the delay counter is loaded with DLY_EVEN if apu_cycle_pulse_in is high in that clk, else DLY_ODD. State goes to DELAY.
  - If d_in[6]=1, the IRQ flag clears on the accepting clk.
- DELAY state:
  - Each cpu_cycle_pulse_in without a new accepted write decrements the counter.
  - When the counter equals 1 and cpu_cycle_pulse_in is high, mode_wr_out is asserted combinationally in that clk and the state returns to IDLE.
  - mode_wr_out is therefore only ever high together with cpu_cycle_pulse_in, which the frame counter requires for its reload to 0x48D0.
  - busy_out = (state==DELAY).
- Write during DELAY: the new write restarts the delay and the old write is dropped (last write wins). This includes a write landing on the expiry clk; in that case mode_wr_out stays low that clk and the new delay starts.
- Immediate clock: in the clk where mode_wr_out=1 and mode_out[1]=1, e_pulse_out and l_pulse_out are asserted for 1 clk. The frame counter's own mode latch has not yet updated in that clk, so this controller generates the pulse.
- Merge: e_pulse_out = fc_e_pulse_in | imm; l_pulse_out = fc_l_pulse_in | imm. The merge is combinational with zero latency.
- IRQ flag:
  - Set on fc_f_pulse_in.
  - Cleared on status_rd_in & cpu_cycle_pulse_in, or on an accepted write with d_in[6]=1.
  - Priority: set wins over a status-read clear in the same clk. An inhibit-write clear wins over set in the same clk.
  - irq_out is the registered flag, visible 1 clk after the set/clear event.
- State machine: IDLE -> DELAY on an accepted write. DELAY -> DELAY on a re-write or a decrement. DELAY -> IDLE on expiry.

Decomposition:
- apu_pkg holds DLY_EVEN/DLY_ODD defaults, the state enum (IDLE, DELAY), and the $4017 bit-position constants (SEQ_BIT=7, INH_BIT=6).
- No sub-module; the delay counter and IRQ flag are small enough to stay inline.
- Top-level instantiates apu_frame_ctrl beside apu_frame_counter and wires mode_out/mode_wr_out directly to it.

Test Plan:
1. Write $80 on a clk where apu_cycle_pulse_in=1 -> mode_out=2'b10 on the next clk and busy_out=1. mode_wr_out, e_pulse_out and l_pulse_out are all 1 on the 3rd subsequent cpu pulse, then busy_out=0.
2. Write $00 on a CPU cycle without an APU pulse -> mode_wr_out is 1 on the 4th subsequent cpu pulse. e/l pulses are not asserted. The frame counter reloads, then emits its first fc_e_pulse after 0x0E90 APU cycles, which passes through to e_pulse_out.
3. fc_f_pulse_in=1 -> irq_out=1 next clk. status_rd_in with cpu pulse -> irq_out=0 next clk. fc_f_pulse_in in the same clk as the read -> irq_out stays 1.
4. With irq_out=1, write $40 -> irq_out=0 next clk (immediate, not delayed). mode_wr_out still fires after the delay with mode_out=2'b01.
5. Write $80, then write $00 two cpu pulses later -> only one mode_wr_out, 3 or 4 pulses after the second write. mode_out=2'b00 and no immediate e/l pulse.
6. Write $80, assert rst_in asynchronously (mid-clk) one cpu pulse later -> all outputs 0 immediately. No mode_wr_out for 10 subsequent cpu pulses.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants and types for the APU frame-counter control logic.
package apu_pkg;

    localparam int unsigned DLY_EVEN_DEF = 3;
    localparam int unsigned DLY_ODD_DEF  = 4;
    localparam int unsigned CNT_W_DEF    = 3;

    // $4017 bit positions
    localparam int unsigned SEQ_BIT = 7;
    localparam int unsigned INH_BIT = 6;

    typedef enum logic [0:0] {
        StIdle,
        StDelay
    } fc_state_e;

endpackage

// File: rtl/apu_frame_ctrl.sv
// $4017 write capture, delayed mode apply, frame IRQ flag and immediate quarter/half-frame
// clock merge for the APU frame counter.
import apu_pkg::*;

module apu_frame_ctrl #(
    parameter int unsigned DLY_EVEN = DLY_EVEN_DEF,
    parameter int unsigned DLY_ODD  = DLY_ODD_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       cpu_cycle_pulse_in,
    input  logic       apu_cycle_pulse_in,
    input  logic       wr_in,
    input  logic [7:0] d_in,
    input  logic       status_rd_in,
    input  logic       fc_e_pulse_in,
    input  logic       fc_l_pulse_in,
    input  logic       fc_f_pulse_in,
    output logic [1:0] mode_out,
    output logic       mode_wr_out,
    output logic       e_pulse_out,
    output logic       l_pulse_out,
    output logic       irq_out,
    output logic       busy_out
);

    fc_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       mode_q;
    logic             irq_q;
    logic             irq_d;

    logic accept;
    logic expire;
    logic inh_clr;
    logic rd_clr;
    logic imm;

    // Only the mode/inhibit bits of $4017 matter here.
    logic unused_d;
    assign unused_d = ^d_in[5:0];

    assign accept  = wr_in & cpu_cycle_pulse_in;
    assign expire  = (state_q == StDelay) & (cnt_q == CNT_W'(1)) & cpu_cycle_pulse_in & ~accept;
    assign inh_clr = accept & d_in[INH_BIT];
    assign rd_clr  = status_rd_in & cpu_cycle_pulse_in;

    // The counter's own mode latch lags by one clk, so the 5-step immediate clock comes from here.
    assign imm = expire & mode_q[1];

    always_comb begin
        irq_d = irq_q;
        if (inh_clr) begin
            irq_d = 1'b0;
        end else if (fc_f_pulse_in) begin
            irq_d = 1'b1;
        end else if (rd_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            irq_q   <= 1'b0;
        end else begin
            irq_q <= irq_d;
            if (accept) begin
                // Last write wins, including one landing on the expiry clk.
                mode_q  <= {d_in[SEQ_BIT], d_in[INH_BIT]};
                cnt_q   <= apu_cycle_pulse_in ? CNT_W'(DLY_EVEN) : CNT_W'(DLY_ODD);
                state_q <= StDelay;
            end else if ((state_q == StDelay) && cpu_cycle_pulse_in) begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign mode_out    = mode_q;
    assign mode_wr_out = expire;
    assign e_pulse_out = fc_e_pulse_in | imm;
    assign l_pulse_out = fc_l_pulse_in | imm;
    assign irq_out     = irq_q;
    assign busy_out    = (state_q == StDelay);

endmodule

// File: tb/tb_apu_frame_ctrl.sv
// Self-checking bench for apu_frame_ctrl: per-CPU-cycle vector table through a scoreboard,
// plus hand-written reset and status-read corner cases.
module tb_apu_frame_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       cpu_cycle_pulse_in = 1'b0;
    logic       apu_cycle_pulse_in = 1'b0;
    logic       wr_in = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       status_rd_in = 1'b0;
    logic       fc_e_pulse_in = 1'b0;
    logic       fc_l_pulse_in = 1'b0;
    logic       fc_f_pulse_in = 1'b0;
    logic [1:0] mode_out;
    logic       mode_wr_out;
    logic       e_pulse_out;
    logic       l_pulse_out;
    logic       irq_out;
    logic       busy_out;

    int checks = 0;
    int errors = 0;

    apu_frame_ctrl dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .cpu_cycle_pulse_in (cpu_cycle_pulse_in),
        .apu_cycle_pulse_in (apu_cycle_pulse_in),
        .wr_in              (wr_in),
        .d_in               (d_in),
        .status_rd_in       (status_rd_in),
        .fc_e_pulse_in      (fc_e_pulse_in),
        .fc_l_pulse_in      (fc_l_pulse_in),
        .fc_f_pulse_in      (fc_f_pulse_in),
        .mode_out           (mode_out),
        .mode_wr_out        (mode_wr_out),
        .e_pulse_out        (e_pulse_out),
        .l_pulse_out        (l_pulse_out),
        .irq_out            (irq_out),
        .busy_out           (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rd;
        logic       apu;
        logic       fce;
        logic       fcl;
        logic       fcf;
        logic       xwr;
        logic       xe;
        logic       xl;
        logic       xbusy;
        logic       xirq;
        logic [1:0] xmode;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(logic wr, logic [7:0] d, logic rd, logic apu, logic fce,
                                logic fcl, logic fcf, logic xwr, logic xe, logic xl,
                                logic xbusy, logic xirq, logic [1:0] xmode);
        vec_t v;
        v.wr = wr; v.d = d; v.rd = rd; v.apu = apu;
        v.fce = fce; v.fcl = fcl; v.fcf = fcf;
        v.xwr = xwr; v.xe = xe; v.xl = xl;
        v.xbusy = xbusy; v.xirq = xirq; v.xmode = xmode;
        return v;
    endfunction

    function automatic vec_t idle(logic xbusy, logic xirq, logic [1:0] xmode);
        return mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, xbusy, xirq, xmode);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One CPU cycle: a pulse clk carrying the vector, then a quiet clk.
    task automatic step(input vec_t v, input int idx);
        vec_t x;
        @(posedge clk_in); #1;
        cpu_cycle_pulse_in = 1'b1;
        wr_in = v.wr; d_in = v.d; status_rd_in = v.rd; apu_cycle_pulse_in = v.apu;
        fc_e_pulse_in = v.fce; fc_l_pulse_in = v.fcl; fc_f_pulse_in = v.fcf;
        sb.push_back(v);
        @(negedge clk_in);
        x = sb.pop_front();
        chk($sformatf("mode_wr[%0d]", idx), {7'd0, mode_wr_out}, {7'd0, x.xwr});
        chk($sformatf("e_pulse[%0d]", idx), {7'd0, e_pulse_out}, {7'd0, x.xe});
        chk($sformatf("l_pulse[%0d]", idx), {7'd0, l_pulse_out}, {7'd0, x.xl});
        @(posedge clk_in); #1;
        cpu_cycle_pulse_in = 1'b0; wr_in = 1'b0; status_rd_in = 1'b0; apu_cycle_pulse_in = 1'b0;
        fc_e_pulse_in = 1'b0; fc_l_pulse_in = 1'b0; fc_f_pulse_in = 1'b0;
        chk($sformatf("busy[%0d]", idx), {7'd0, busy_out}, {7'd0, x.xbusy});
        chk($sformatf("irq[%0d]", idx), {7'd0, irq_out}, {7'd0, x.xirq});
        chk($sformatf("mode[%0d]", idx), {6'd0, mode_out}, {6'd0, x.xmode});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        vecs.push_back(idle(0, 0, 2'b00));
        // $80 on an APU cycle: apply on the 3rd pulse with immediate clock
        vecs.push_back(mk(1, 8'h80, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10));
        vecs.push_back(idle(1, 0, 2'b10));
        vecs.push_back(idle(1, 0, 2'b10));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b10));
        // $00 off an APU cycle: apply on the 4th pulse, no immediate clock
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00));
        vecs.push_back(idle(1, 0, 2'b00));
        vecs.push_back(idle(1, 0, 2'b00));
        vecs.push_back(idle(1, 0, 2'b00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        // frame counter pulse pass-through
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00));
        // IRQ set / read clear / set beats read
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00));
        // $40 clears IRQ immediately, applies later
        vecs.push_back(mk(1, 8'h40, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01));
        vecs.push_back(idle(1, 0, 2'b01));
        vecs.push_back(idle(1, 0, 2'b01));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01));
        // inhibit-write clear beats a simultaneous frame pulse
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b01));
        vecs.push_back(mk(1, 8'h40, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b01));
        vecs.push_back(idle(1, 0, 2'b01));
        vecs.push_back(idle(1, 0, 2'b01));
        vecs.push_back(idle(1, 0, 2'b01));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01));
        // re-write two pulses later: single apply for the second write
        vecs.push_back(mk(1, 8'h80, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10));
        vecs.push_back(idle(1, 0, 2'b10));
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00));
        vecs.push_back(idle(1, 0, 2'b00));
        vecs.push_back(idle(1, 0, 2'b00));
        vecs.push_back(idle(1, 0, 2'b00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        // write landing on the expiry clk suppresses that apply
        vecs.push_back(mk(1, 8'h80, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10));
        vecs.push_back(idle(1, 0, 2'b10));
        vecs.push_back(idle(1, 0, 2'b10));
        vecs.push_back(mk(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00));
        vecs.push_back(idle(1, 0, 2'b00));
        vecs.push_back(idle(1, 0, 2'b00));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00));

        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        foreach (vecs[i]) step(vecs[i], i);

        // status read without a CPU pulse must not clear the flag
        step(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00), 100);
        @(posedge clk_in); #1 status_rd_in = 1'b1;
        @(posedge clk_in); #1 status_rd_in = 1'b0;
        chk("irq_rd_no_pulse", {7'd0, irq_out}, 8'd1);

        // asynchronous reset mid-clk while a write is pending
        step(mk(1, 8'h80, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10), 101);
        step(idle(1, 1, 2'b10), 102);
        #2 rst_in = 1'b1;
        #1;
        chk("rst_mode", {6'd0, mode_out}, 8'd0);
        chk("rst_busy", {7'd0, busy_out}, 8'd0);
        chk("rst_irq", {7'd0, irq_out}, 8'd0);
        chk("rst_mode_wr", {7'd0, mode_wr_out}, 8'd0);
        @(posedge clk_in); #1 rst_in = 1'b0;
        for (int k = 0; k < 10; k++) step(idle(0, 0, 2'b00), 200 + k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
